ppu_vram_port: RTL and testbench

- Sequences all accesses to the PPU memory block (single synchronous read port, separate write port, internal address decode).
- Implements the CPU-visible PPUADDR/PPUDATA path: $2006 address latch, $2007 read buffer, auto-increment of 1 or 32.
- Arbitrates the memory read port between the renderer fetch unit, which has fixed priority, and CPU $2007 reads.
- Sits between the CPU register bus decode and the PPU memory block.

---
 rtl/ppu_pkg.sv | 30 +++
 rtl/ppu_read_arb.sv | 37 +++
 rtl/ppu_vram_port.sv | 197 +++++++++++++++++++
 tb/tb_ppu_vram_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU VRAM access path: CPU register indices,
// palette address constants and the $2007 read sequencer states.
package ppu_pkg;

   // CPU-visible register indices (low three address bits of $2000-$2007)
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_ADDR   = 3'd6;
   localparam logic [2:0] REG_DATA   = 3'd7;

   // Addresses at or above PAL_BASE read palette RAM directly; the read
   // buffer is refilled from the nametable byte PAL_SHADOW_OFS below.
   localparam logic [13:0] PAL_BASE       = 14'h3F00;
   localparam logic [13:0] PAL_SHADOW_OFS = 14'h1000;

   // $2007 read sequencer.
   //   IDLE    : no CPU read in flight
   //   RD1     : waiting for the read port to drive address a
   //   RD1_CAP : memory data for a is valid
   //   RD2     : palette only, waiting to drive a - PAL_SHADOW_OFS
   //   RD2_CAP : shadow nametable byte is valid
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD1     = 3'd1,
      RD1_CAP = 3'd2,
      RD2     = 3'd3,
      RD2_CAP = 3'd4
   } rd_state_t;

endpackage

// File: rtl/ppu_read_arb.sv
// Read-port arbiter for the PPU memory block. The renderer has fixed
// priority; the CPU read sequencer only gets the port in cycles where the
// renderer is not requesting. Kept separate so further requesters can be
// slotted in below the renderer.
module ppu_read_arb #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rnd_req,
   input  logic [ADDR_W-1:0] rnd_addr,
   input  logic              cpu_rd_en,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_grant,
   output logic [15:0]       mem_read_addr,
   output logic              rnd_valid
);

   // Priority mux onto the single synchronous read port
   always_comb begin
      mem_read_addr = '0;
      cpu_grant     = 1'b0;
      if (rnd_req) begin
         mem_read_addr = 16'(rnd_addr);
      end else if (cpu_rd_en) begin
         mem_read_addr = 16'(cpu_rd_addr);
         cpu_grant     = 1'b1;
      end
   end

   // Renderer data returns one cycle after its address, so valid follows req
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rnd_valid <= 1'b0;
      else      rnd_valid <= rnd_req;
   end

endmodule

// File: rtl/ppu_vram_port.sv
// CPU PPUADDR/PPUDATA path in front of the PPU memory block: $2006 address
// latch with write toggle, $2007 writes straight to the write port, $2007
// reads through the buffered read sequencer sharing the read port with the
// renderer.
//
// CPU handshake: a request is taken in any cycle with cpu_req=1 and
// cpu_busy=0; everything else on cpu_req is ignored and must be retried.
// Every accepted access completes with exactly one cpu_ack pulse, with
// cpu_rdata valid in that same cycle. cpu_busy is high only while a $2007
// read is in flight and falls in its ack cycle.
module ppu_vram_port #(
   parameter int                ADDR_W         = 14,
   parameter logic [ADDR_W-1:0] PAL_BASE       = 14'h3F00,
   parameter logic [ADDR_W-1:0] PAL_SHADOW_OFS = 14'h1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_reg,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_busy,
   input  logic              rnd_req,
   input  logic [ADDR_W-1:0] rnd_addr,
   output logic [7:0]        rnd_rdata,
   output logic              rnd_valid,
   output logic [15:0]       mem_read_addr,
   input  logic [7:0]        mem_read_data,
   output logic [15:0]       mem_write_addr,
   output logic [7:0]        mem_write_data,
   output logic              mem_write_en
);

   import ppu_pkg::*;

   rd_state_t         state;
   rd_state_t         state_next;

   logic [ADDR_W-1:0] v;        // current VRAM address
   logic [ADDR_W-9:0] t_hi;     // high byte held between the two $2006 writes
   logic              w;        // $2006 write toggle
   logic              inc32;    // 1: step v by 32 per $2007 access
   logic [7:0]        rbuf;     // $2007 read buffer
   logic [7:0]        pal;      // palette byte held while the shadow read runs
   logic [ADDR_W-1:0] a;        // address of the $2007 read in flight

   logic              accept;
   logic              rd_start;
   logic              cap_lo;
   logic              cap_pal;
   logic              cap_shadow;
   logic              cpu_rd_en;
   logic [ADDR_W-1:0] cpu_rd_addr;
   logic              cpu_grant;
   logic [ADDR_W-1:0] v_step;

   assign accept    = cpu_req & ~cpu_busy;
   assign v_step    = inc32 ? ADDR_W'(32) : ADDR_W'(1);
   assign rnd_rdata = mem_read_data;

   // CPU read asks for the port in the two address phases of the sequence
   assign cpu_rd_en   = (state == RD1) || (state == RD2);
   assign cpu_rd_addr = (state == RD2) ? (a - PAL_SHADOW_OFS) : a;

   ppu_read_arb #(
      .ADDR_W (ADDR_W)
   ) u_read_arb (
      .clk           (clk),
      .rst           (rst),
      .rnd_req       (rnd_req),
      .rnd_addr      (rnd_addr),
      .cpu_rd_en     (cpu_rd_en),
      .cpu_rd_addr   (cpu_rd_addr),
      .cpu_grant     (cpu_grant),
      .mem_read_addr (mem_read_addr),
      .rnd_valid     (rnd_valid)
   );

   // Read sequencer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Read sequencer next state and capture strobes
   always_comb begin
      state_next = state;
      rd_start   = 1'b0;
      cap_lo     = 1'b0;
      cap_pal    = 1'b0;
      cap_shadow = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !cpu_we && (cpu_reg == REG_DATA)) begin
               rd_start   = 1'b1;
               state_next = RD1;
            end
         end
         RD1: begin
            if (cpu_grant) state_next = RD1_CAP;
         end
         RD1_CAP: begin
            if (a >= PAL_BASE) begin
               cap_pal    = 1'b1;
               state_next = RD2;
            end else begin
               cap_lo     = 1'b1;
               state_next = IDLE;
            end
         end
         RD2: begin
            if (cpu_grant) state_next = RD2_CAP;
         end
         RD2_CAP: begin
            cap_shadow = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Register file, write port and CPU response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v              <= '0;
         t_hi           <= '0;
         w              <= 1'b0;
         inc32          <= 1'b0;
         rbuf           <= '0;
         pal            <= '0;
         a              <= '0;
         cpu_ack        <= 1'b0;
         cpu_rdata      <= '0;
         cpu_busy       <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_write_addr <= '0;
         mem_write_data <= '0;
      end else begin
         cpu_ack      <= 1'b0;
         cpu_rdata    <= '0;
         mem_write_en <= 1'b0;

         if (accept) begin
            if (cpu_we) begin
               cpu_ack <= 1'b1;
               case (cpu_reg)
                  REG_CTRL: inc32 <= cpu_wdata[2];
                  REG_ADDR: begin
                     if (!w) begin
                        t_hi <= cpu_wdata[ADDR_W-9:0];
                        w    <= 1'b1;
                     end else begin
                        v <= {t_hi, cpu_wdata};
                        w <= 1'b0;
                     end
                  end
                  REG_DATA: begin
                     mem_write_en   <= 1'b1;
                     mem_write_addr <= 16'(v);
                     mem_write_data <= cpu_wdata;
                     v              <= v + v_step;
                  end
                  default: ;
               endcase
            end else if (rd_start) begin
               // $2007 read: ack comes from the sequencer
               a        <= v;
               cpu_busy <= 1'b1;
            end else begin
               cpu_ack <= 1'b1;
               if (cpu_reg == REG_STATUS) w <= 1'b0;
            end
         end

         if (cap_lo) begin
            cpu_rdata <= rbuf;
            rbuf      <= mem_read_data;
            cpu_ack   <= 1'b1;
            cpu_busy  <= 1'b0;
            v         <= v + v_step;
         end

         if (cap_pal) pal <= mem_read_data;

         if (cap_shadow) begin
            cpu_rdata <= pal;
            rbuf      <= mem_read_data;
            cpu_ack   <= 1'b1;
            cpu_busy  <= 1'b0;
            v         <= v + v_step;
         end
      end
   end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: directed register sequences against a behavioural
// memory, with expected acks, writes and renderer returns queued by the
// drivers and checked by an independent monitor.
module tb_ppu_vram_port;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [2:0]  cpu_reg = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_busy;
   logic        rnd_req = 1'b0;
   logic [13:0] rnd_addr = '0;
   logic [7:0]  rnd_rdata;
   logic        rnd_valid;
   logic [15:0] mem_read_addr;
   logic [7:0]  mem_read_data = '0;
   logic [15:0] mem_write_addr;
   logic [7:0]  mem_write_data;
   logic        mem_write_en;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [23:0] ack_q[$];   // {ack cycle, cpu_rdata}
   logic [23:0] wr_q[$];    // {write address, write data}
   logic [7:0]  rnd_q[$];   // renderer return data
   logic        rnd_prev = 1'b0;

   logic [7:0]  mem [0:16383];

   ppu_vram_port dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_reg        (cpu_reg),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_ack        (cpu_ack),
      .cpu_busy       (cpu_busy),
      .rnd_req        (rnd_req),
      .rnd_addr       (rnd_addr),
      .rnd_rdata      (rnd_rdata),
      .rnd_valid      (rnd_valid),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory block: synchronous read, separate write port
   always @(posedge clk) begin
      mem_read_data <= mem[mem_read_addr[13:0]];
      if (mem_write_en) mem[mem_write_addr[13:0]] = mem_write_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a response
   always @(negedge clk) begin
      logic [23:0] e;
      logic [7:0]  r;
      if (!rst) begin
         rnd_prev = 1'b0;
      end else begin
         if (cpu_ack) begin
            if (ack_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected cpu_ack: got rdata %0h, none expected (cycle %0d)", cpu_rdata, cyc);
            end else begin
               e = ack_q.pop_front();
               check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e[7:0]});
               check("ack cycle", cyc, {16'd0, e[23:8]});
            end
         end
         if (mem_write_en) begin
            if (wr_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected write: got addr %0h data %0h (cycle %0d)", mem_write_addr, mem_write_data, cyc);
            end else begin
               e = wr_q.pop_front();
               check("mem_write_addr", {16'd0, mem_write_addr}, {16'd0, e[23:8]});
               check("mem_write_data", {24'd0, mem_write_data}, {24'd0, e[7:0]});
            end
         end
         check("rnd_valid", {31'd0, rnd_valid}, {31'd0, rnd_prev});
         if (rnd_valid && rnd_q.size() != 0) begin
            r = rnd_q.pop_front();
            check("rnd_rdata", {24'd0, rnd_rdata}, {24'd0, r});
         end
         if (rnd_req) begin
            check("mem_read_addr renderer", {16'd0, mem_read_addr}, {18'd0, rnd_addr});
            rnd_q.push_back(mem[rnd_addr]);
         end
         rnd_prev = rnd_req;
      end
   end

   // One CPU access; returns in the ack cycle
   task automatic cpu_access(input logic we, input logic [2:0] r, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input int lat,
                             input logic [15:0] exp_raddr, input bit chk_raddr);
      int n;
      cpu_we    = we;
      cpu_reg   = r;
      cpu_wdata = wd;
      cpu_req   = 1'b1;
      ack_q.push_back({cyc[15:0] + 16'(lat), exp_rd});
      @(posedge clk); #1;
      cpu_req = 1'b0;
      if (chk_raddr) begin
         check("cpu_busy during read", {31'd0, cpu_busy}, 32'd1);
         check("mem_read_addr cpu", {16'd0, mem_read_addr}, {16'd0, exp_raddr});
      end
      n = 1;
      while (!cpu_ack && n < lat + 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cpu_ack) begin
         checks++; fails++;
         $display("FAIL ack timeout: no cpu_ack after %0d cycles, required at %0d", n, lat);
      end else begin
         check("cpu_busy at ack", {31'd0, cpu_busy}, 32'd0);
      end
   endtask

   task automatic wr(input logic [2:0] r, input logic [7:0] d);
      cpu_access(1'b1, r, d, 8'h00, 1, 16'h0, 1'b0);
   endtask

   task automatic rd(input logic [2:0] r);
      cpu_access(1'b0, r, 8'h00, 8'h00, 1, 16'h0, 1'b0);
   endtask

   task automatic w7(input logic [7:0] d, input logic [15:0] exp_addr);
      wr_q.push_back({exp_addr, d});
      cpu_access(1'b1, 3'd7, d, 8'h00, 1, 16'h0, 1'b0);
   endtask

   task automatic rd7(input logic [7:0] exp_rd, input logic [15:0] exp_addr, input int lat);
      cpu_access(1'b0, 3'd7, 8'h00, exp_rd, lat, exp_addr, 1'b1);
   endtask

   task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
      wr(3'd6, hi);
      wr(3'd6, lo);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " cpu_ack"},        {31'd0, cpu_ack},      32'd0);
      check({tag, " cpu_busy"},       {31'd0, cpu_busy},     32'd0);
      check({tag, " cpu_rdata"},      {24'd0, cpu_rdata},    32'd0);
      check({tag, " mem_write_en"},   {31'd0, mem_write_en}, 32'd0);
      check({tag, " mem_write_addr"}, {16'd0, mem_write_addr}, 32'd0);
      check({tag, " mem_write_data"}, {24'd0, mem_write_data}, 32'd0);
      check({tag, " mem_read_addr"},  {16'd0, mem_read_addr}, 32'd0);
      check({tag, " rnd_valid"},      {31'd0, rnd_valid},    32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      mem[14'h2000] = 8'h11;
      mem[14'h2001] = 8'h22;
      mem[14'h3F00] = 8'h0F;
      mem[14'h2F00] = 8'h55;
      for (int i = 0; i < 10; i++) mem[14'h0100 + 14'(i)] = 8'h80 + 8'(i);

      // reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // $2006/$2007 write path
      set_v(8'h21, 8'h05);
      w7(8'hAB, 16'h2105);
      w7(8'hCD, 16'h2106);

      // increment by 32
      wr(3'd0, 8'h04);
      set_v(8'h21, 8'h05);
      w7(8'h01, 16'h2105);
      w7(8'h02, 16'h2125);
      wr(3'd0, 8'h00);
      w7(8'h03, 16'h2145);

      // buffered non-palette reads
      set_v(8'h20, 8'h00);
      rd7(8'h00, 16'h2000, 3);
      rd7(8'h11, 16'h2001, 3);

      // palette read, then v and read buffer after it
      set_v(8'h3F, 8'h00);
      rd7(8'h0F, 16'h3F00, 5);
      w7(8'h77, 16'h3F01);
      set_v(8'h20, 8'h01);
      rd7(8'h55, 16'h2001, 3);

      // read stalled by 10 cycles of renderer traffic
      fork
         cpu_access(1'b0, 3'd7, 8'h00, 8'h22, 13, 16'h0, 1'b0);
         begin
            @(posedge clk); #1;
            rnd_req = 1'b1;
            for (int i = 0; i < 10; i++) begin
               rnd_addr = 14'h0100 + 14'(i);
               @(posedge clk); #1;
            end
            rnd_req = 1'b0;
         end
      join

      // status and unused register accesses
      rd(3'd2);
      rd(3'd1);

      // v wraps at the top of the address space
      set_v(8'h3F, 8'hFF);
      w7(8'h10, 16'h3FFF);
      w7(8'h11, 16'h0000);

      // write toggle cleared by $2002
      wr(3'd6, 8'h3F);
      rd(3'd2);
      wr(3'd6, 8'h12);
      w7(8'h20, 16'h0001);
      wr(3'd6, 8'h34);
      w7(8'h21, 16'h1234);
      wr(3'd5, 8'hFF);
      w7(8'h22, 16'h1235);
      set_v(8'h12, 8'h34);
      rd7(8'h00, 16'h1234, 3);
      rd7(8'h21, 16'h1235, 3);

      // reset in the middle of a palette read
      set_v(8'h3F, 8'h00);
      cpu_we  = 1'b0;
      cpu_reg = 3'd7;
      cpu_req = 1'b1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid-read reset");
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      w7(8'h55, 16'h0000);
      set_v(8'h12, 8'h34);
      rd7(8'h00, 16'h1234, 3);

      // drain
      repeat (5) @(posedge clk);
      #1;
      if (ack_q.size() != 0) begin
         checks++; fails++;
         $display("FAIL ack queue: got %0d acks missing, required 0", ack_q.size());
      end
      if (wr_q.size() != 0) begin
         checks++; fails++;
         $display("FAIL write queue: got %0d writes missing, required 0", wr_q.size());
      end
      if (rnd_q.size() != 0) begin
         checks++; fails++;
         $display("FAIL renderer queue: got %0d returns missing, required 0", rnd_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
